// File: rtl/jtag_bus_pkg.sv
// Field positions of the JTAG control/status words and the bus-bridge FSM encoding.
package jtag_bus_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 16;

    localparam int CTRL_TOG_BIT   = 31;
    localparam int CTRL_WR_BIT    = 30;
    localparam int CTRL_ADDR_MSB  = 23;
    localparam int CTRL_ADDR_LSB  = 16;
    localparam int CTRL_WDATA_MSB = 15;
    localparam int CTRL_WDATA_LSB = 0;

    localparam int STAT_DONE_BIT  = 31;
    localparam int STAT_BUSY_BIT  = 30;
    localparam int STAT_ERR_BIT   = 29;
    localparam int STAT_ADDR_MSB  = 23;
    localparam int STAT_ADDR_LSB  = 16;
    localparam int STAT_DATA_MSB  = 15;
    localparam int STAT_DATA_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/synchronizer.sv
// Multi-flop synchronizer for a single slowly-toggling control bit.
module synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/jtag_register_to_bus.sv
// Bridges a JTAG data-register command word onto a simple req/ack bus using
// toggle handshakes, with a bounded wait for the slave acknowledge.
module jtag_register_to_bus
    import jtag_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int SYNC_STAGES    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       control,
    output logic [31:0]       status,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t              state_q, state_d;
    logic                tog_sync;
    logic                acc_tog_q, acc_tog_d;
    logic                done_tog_q, done_tog_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [ADDR_W-1:0]   st_addr_q, st_addr_d;
    logic [DATA_W-1:0]   st_data_q, st_data_d;

    // Only the toggle crosses domains; the other fields are stable by the time it arrives.
    synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_tog_sync (
        .clk (clk),
        .rst (rst),
        .d_i (control[CTRL_TOG_BIT]),
        .q_o (tog_sync)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            acc_tog_q  <= 1'b0;
            done_tog_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            st_addr_q  <= '0;
            st_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            acc_tog_q  <= acc_tog_d;
            done_tog_q <= done_tog_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            st_addr_q  <= st_addr_d;
            st_data_q  <= st_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_tog_d  = acc_tog_q;
        done_tog_d = done_tog_q;
        busy_d     = busy_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        st_addr_d  = st_addr_q;
        st_data_d  = st_data_q;
        case (state_q)
            ST_IDLE: begin
                if (tog_sync != acc_tog_q) begin
                    state_d   = ST_REQ;
                    acc_tog_d = tog_sync;
                    busy_d    = 1'b1;
                    wr_d      = control[CTRL_WR_BIT];
                    addr_d    = control[CTRL_ADDR_MSB:CTRL_ADDR_LSB];
                    wdata_d   = control[CTRL_WDATA_MSB:CTRL_WDATA_LSB];
                    cnt_d     = '0;
                end
            end
            ST_REQ: begin
                // An ack in the last counted cycle takes priority over the timeout.
                if (bus_ack) begin
                    state_d   = ST_DONE;
                    err_d     = 1'b0;
                    st_addr_d = addr_q;
                    st_data_d = wr_q ? '0 : bus_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_DONE;
                    err_d     = 1'b1;
                    st_addr_d = addr_q;
                    st_data_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                // Done toggle trails the result fields by one cycle so the host reads settled data.
                state_d    = ST_IDLE;
                done_tog_d = acc_tog_q;
                busy_d     = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bus_req   = (state_q == ST_REQ);
        bus_wr    = wr_q;
        bus_addr  = addr_q;
        bus_wdata = wdata_q;
        status    = {done_tog_q, busy_q, err_q, 5'b0, st_addr_q, st_data_q};
    end

endmodule

// File: tb/tb_jtag_register_to_bus.sv
// Directed bench for the JTAG-to-bus bridge: write, read, timeout, pending toggles and reset.
module tb_jtag_register_to_bus;

    localparam int TO_CYC = 8;
    localparam int SYNC   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] control = 32'h0;
    logic [31:0] status;
    logic        bus_req;
    logic        bus_wr;
    logic [7:0]  bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [15:0] bus_rdata = 16'h0;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    logic [31:0] prev_status = 32'h0;
    logic        prev_req = 1'b0;
    logic [24:0] prev_bus = 25'h0;

    jtag_register_to_bus #(
        .TIMEOUT_CYCLES (TO_CYC),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .control   (control),
        .status    (status),
        .bus_req   (bus_req),
        .bus_wr    (bus_wr),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    // Watches every cycle: done toggle never moves with the result fields, bus fields hold during req.
    always @(posedge clk) begin
        logic r;
        r = rst;
        #1;
        if (mon_en && !r) begin
            if (status !== prev_status) begin
                checks++;
                if ((status[31] !== prev_status[31]) && (status[29:0] !== prev_status[29:0])) begin
                    errors++;
                    $display("FAIL status_split: status %h prev %h, done bit moved with data", status, prev_status);
                end
            end
            if (prev_req && bus_req) begin
                checks++;
                if ({bus_wr, bus_addr, bus_wdata} !== prev_bus) begin
                    errors++;
                    $display("FAIL bus_stable: got %h expected %h", {bus_wr, bus_addr, bus_wdata}, prev_bus);
                end
            end
        end
        prev_status = status;
        prev_req    = bus_req;
        prev_bus    = {bus_wr, bus_addr, bus_wdata};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output int lat);
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (bus_req) begin
                lat = i;
                break;
            end
        end
    endtask

    // Acts as the bus slave; returns the number of cycles bus_req was seen high.
    task automatic serve(input int ack_delay, input logic [15:0] rdata, output int n);
        n = 1;
        if (ack_delay >= 0) begin
            repeat (ack_delay) begin
                tick();
                if (bus_req) n++;
            end
            bus_ack   = 1'b1;
            bus_rdata = rdata;
            tick();
            bus_ack   = 1'b0;
            bus_rdata = 16'h0;
            if (bus_req) n++;
        end else begin
            for (int i = 0; i < 100 && bus_req; i++) begin
                tick();
                if (bus_req) n++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        control = 32'h0;
        repeat (3) tick();
        checks++;
        if (status !== 32'h0) begin
            errors++;
            $display("FAIL reset_status: got %h expected %h", status, 32'h0);
        end
        checks++;
        if (bus_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_req: got %b expected 0", bus_req);
        end
        rst = 1'b0;
        repeat (4) tick();
        checks++;
        if (bus_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: got %b expected 0", bus_req);
        end
        $display("test_reset done: status=%h", status);
    endtask

    task automatic test_write();
        int lat, n;
        control = 32'hC012_ABCD;
        wait_req(lat);
        checks++;
        if (lat == 0 || lat > SYNC + 2) begin
            errors++;
            $display("FAIL write_latency: got %0d expected 1..%0d", lat, SYNC + 2);
        end
        checks++;
        if ({bus_wr, bus_addr, bus_wdata} !== {1'b1, 8'h12, 16'hABCD}) begin
            errors++;
            $display("FAIL write_fields: got %b %h %h expected 1 12 abcd", bus_wr, bus_addr, bus_wdata);
        end
        serve(3, 16'hDEAD, n);
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL write_req_cycles: got %0d expected 4", n);
        end
        checks++;
        if (status !== 32'h4012_0000) begin
            errors++;
            $display("FAIL write_mid_status: got %h expected %h", status, 32'h4012_0000);
        end
        tick();
        checks++;
        if (status !== 32'h8012_0000) begin
            errors++;
            $display("FAIL write_status: got %h expected %h", status, 32'h8012_0000);
        end
        $display("test_write: lat=%0d req_cycles=%0d status=%h", lat, n, status);
    endtask

    task automatic test_read();
        int lat, n;
        control = 32'h0034_0000;
        wait_req(lat);
        checks++;
        if (lat == 0 || {bus_wr, bus_addr} !== {1'b0, 8'h34}) begin
            errors++;
            $display("FAIL read_issue: lat %0d got %b %h expected 0 34", lat, bus_wr, bus_addr);
        end
        serve(2, 16'h5A5A, n);
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL read_req_cycles: got %0d expected 3", n);
        end
        checks++;
        if (status !== 32'hC034_5A5A) begin
            errors++;
            $display("FAIL read_mid_status: got %h expected %h", status, 32'hC034_5A5A);
        end
        tick();
        checks++;
        if (status !== 32'h0034_5A5A) begin
            errors++;
            $display("FAIL read_status: got %h expected %h", status, 32'h0034_5A5A);
        end
        bus_ack   = 1'b1;
        bus_rdata = 16'hFFFF;
        tick();
        bus_ack   = 1'b0;
        bus_rdata = 16'h0;
        repeat (3) tick();
        checks++;
        if (status !== 32'h0034_5A5A || bus_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_ack_ignored: status %h req %b expected 00345a5a 0", status, bus_req);
        end
        $display("test_read: req_cycles=%0d status=%h", n, status);
    endtask

    task automatic test_timeout();
        int lat, n;
        control = 32'h8056_0000;
        wait_req(lat);
        serve(-1, 16'h0, n);
        checks++;
        if (n !== TO_CYC) begin
            errors++;
            $display("FAIL timeout_req_cycles: got %0d expected %0d", n, TO_CYC);
        end
        checks++;
        if (status !== 32'h6056_0000) begin
            errors++;
            $display("FAIL timeout_mid_status: got %h expected %h", status, 32'h6056_0000);
        end
        tick();
        checks++;
        if (status !== 32'hA056_0000) begin
            errors++;
            $display("FAIL timeout_status: got %h expected %h", status, 32'hA056_0000);
        end
        $display("test_timeout: req_cycles=%0d status=%h", n, status);
        control = 32'h4077_1111;
        wait_req(lat);
        serve(1, 16'h9999, n);
        tick();
        checks++;
        if (status !== 32'h0077_0000) begin
            errors++;
            $display("FAIL error_clear: got %h expected %h", status, 32'h0077_0000);
        end
        $display("test_timeout clear: status=%h", status);
    endtask

    task automatic test_pending();
        int lat, n;
        control = 32'h8001_0000;
        wait_req(lat);
        control = 32'h4002_2222;
        serve(2, 16'h1111, n);
        checks++;
        if (status !== 32'h4001_1111) begin
            errors++;
            $display("FAIL pending_first_status: got %h expected %h", status, 32'h4001_1111);
        end
        wait_req(lat);
        checks++;
        if (lat == 0 || {bus_wr, bus_addr, bus_wdata} !== {1'b1, 8'h02, 16'h2222}) begin
            errors++;
            $display("FAIL pending_second: lat %0d got %b %h %h expected 1 02 2222", lat, bus_wr, bus_addr, bus_wdata);
        end
        serve(0, 16'h7777, n);
        tick();
        checks++;
        if (status !== 32'h0002_0000) begin
            errors++;
            $display("FAIL pending_status: got %h expected %h", status, 32'h0002_0000);
        end
        $display("test_pending: status=%h", status);
    endtask

    task automatic test_double_toggle();
        int lat, n;
        bit seen;
        control = 32'h8003_0000;
        wait_req(lat);
        control = 32'h0003_0000;
        tick();
        tick();
        control = 32'h8003_0000;
        serve(4, 16'h3333, n);
        tick();
        checks++;
        if (status !== 32'h8003_3333) begin
            errors++;
            $display("FAIL double_status: got %h expected %h", status, 32'h8003_3333);
        end
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (bus_req) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL double_no_cmd: got req %b expected 0", seen);
        end
        $display("test_double_toggle: status=%h extra_req=%b", status, seen);
    endtask

    task automatic test_reset_mid();
        int lat, n;
        bit seen;
        control = 32'h0044_0000;
        wait_req(lat);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus_req !== 1'b0 || status !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: req %b status %h expected 0 00000000", bus_req, status);
        end
        seen = 1'b0;
        repeat (6) begin
            tick();
            if (bus_req) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_quiet: got req %b expected 0", seen);
        end
        control = 32'h8045_0000;
        wait_req(lat);
        checks++;
        if (lat == 0 || bus_addr !== 8'h45) begin
            errors++;
            $display("FAIL reset_mid_fresh: lat %0d addr %h expected 45", lat, bus_addr);
        end
        serve(1, 16'h1234, n);
        tick();
        checks++;
        if (status !== 32'h8045_1234) begin
            errors++;
            $display("FAIL reset_mid_status: got %h expected %h", status, 32'h8045_1234);
        end
        $display("test_reset_mid: status=%h", status);
    endtask

    task automatic test_reset_release();
        int lat, n;
        rst = 1'b1;
        control = 32'h8099_0000;
        tick();
        tick();
        rst = 1'b0;
        wait_req(lat);
        checks++;
        if (lat == 0 || lat > SYNC + 2 || bus_addr !== 8'h99) begin
            errors++;
            $display("FAIL release_cmd: lat %0d addr %h expected <=%0d 99", lat, bus_addr, SYNC + 2);
        end
        serve(0, 16'h0F0F, n);
        tick();
        checks++;
        if (status !== 32'h8099_0F0F) begin
            errors++;
            $display("FAIL release_status: got %h expected %h", status, 32'h8099_0F0F);
        end
        $display("test_reset_release: lat=%0d status=%h", lat, status);
    endtask

    initial begin
        test_reset();
        mon_en = 1'b1;
        test_write();
        test_read();
        test_timeout();
        test_pending();
        test_double_toggle();
        test_reset_mid();
        test_reset_release();
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtag_register_to_bus.md
JTAG_REGISTER_TO_BUS -- requirements
Module: jtag_register_to_bus

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1023, max bus_req cycles without bus_ack before abort (range 1..65535).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, flip-flops per control-toggle synchronizer (min 2).
REQ-003 SHALL have one clock and a synchronous active-high reset: clk, rst; no other clock.
REQ-004 clk  input  1  system clock; all block state is clocked on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 control  input  32  JTAG-domain command word from the JTAG data register; asynchronous to clk.
REQ-007 status  output  32  result word to the JTAG data register capture port.
REQ-008 bus_req  output  1  bus transaction request.
REQ-009 bus_wr  output  1  1=write, 0=read; valid while bus_req=1.
REQ-010 bus_addr  output  8  transaction address; valid while bus_req=1.
REQ-011 bus_wdata  output  16  write data; valid while bus_req=1.
REQ-012 bus_ack  input  1  completion strobe from the bus slave.
REQ-013 bus_rdata  input  16  read data; valid in the cycle bus_ack=1.

Function
REQ-014 control fields SHALL be: [31] cmd toggle, [30] write, [29:24] ignored, [23:16] addr, [15:0] wdata.
REQ-015 status fields SHALL be: [31] done toggle, [30] busy, [29] timeout error, [28:24] zero, [23:16] addr of last command, [15:0] rdata.
REQ-016 control[31] SHALL pass through a SYNC_STAGES synchronizer; control[30:0] SHALL be sampled only in the acceptance cycle, because the host changes all control bits together at Update-DR.
REQ-017 FSM states SHALL be IDLE, REQ, DONE.
REQ-018 IDLE->REQ SHALL occur when the synchronized toggle differs from the accepted toggle; in that cycle, latch write/addr/wdata, copy the synchronized toggle to the accepted toggle, and set busy.
REQ-019 bus_req SHALL assert the cycle after acceptance and stay high, with bus_wr/addr/wdata stable, until bus_ack=1 is sampled.
REQ-020 bus_ack=1 with bus_req=1 in cycle A: REQ->DONE; bus_req=0 in A+1; on a read, capture bus_rdata into status[15:0]; on a write, set status[15:0]=0; clear the error flag.
REQ-021 bus_ack while bus_req=0 SHALL be ignored.
REQ-022 Timeout counter SHALL clear on acceptance and increment each cycle in REQ; when bus_ack is not seen within TIMEOUT_CYCLES bus_req cycles, go REQ->DONE with error=1 and status[15:0]=0; bus_ack in the final counted cycle SHALL win over the timeout.
REQ-023 DONE->IDLE SHALL occur after one cycle; in that transition, done toggle := accepted toggle and busy := 0, exactly one cycle after status[29:0] is updated, so a host seeing the new done toggle reads settled data.
REQ-024 A toggle change during REQ/DONE SHALL be held pending and accepted on return to IDLE; a double toggle inside one busy window is indistinguishable from none and SHALL issue no command.
REQ-025 Latency: a control[31] change SHALL produce bus_req high within SYNC_STAGES+2 clk cycles while the block is IDLE.
REQ-026 status SHALL be driven only from clk registers, with no combinational path from control or bus inputs.

Reset
REQ-027 rst SHALL clear synchronizer flops, accepted toggle, done toggle, busy, error, counter, latched fields, and status to 0, set state=IDLE, and drop bus_req the next cycle, including mid-transaction.
REQ-028 After reset release, if control[31]=1 then one command SHALL execute, per REQ-018.

Structure
REQ-029 Package jtag_bus_pkg SHALL hold the control/status field bit positions and the FSM state enum.
REQ-030 The toggle synchronizer SHALL be the sub-module synchronizer (parameter STAGES, reset to 0); everything else stays in one module.

Verification
REQ-031 Write: control=0xC0_12_ABCD, bus_ack 3 cycles after bus_req -> bus_wr=1, addr=0x12, wdata=0xABCD; status=0x8012_0000; done toggle=1.
REQ-032 Read: toggle back to 0, control=0x00_34_0000, bus_ack with bus_rdata=0x5A5A -> status=0x0034_5A5A; bus_req high exactly until the ack cycle.
REQ-033 Timeout with TIMEOUT_CYCLES=8 and no ack -> bus_req high exactly 8 cycles; status[29]=1; next successful command clears it.
REQ-034 Toggle control[31] while REQ is waiting -> second command issued after DONE->IDLE; two toggles in one busy window -> no second command.
REQ-035 Assert rst during REQ -> bus_req=0 the next cycle; status=0; a later toggle issues a fresh command.
REQ-036 Check that status[31] never changes in the same cycle as status[29:0] across all scenarios.
